heap_cmd_dispatcher: RTL and testbench

HEAP_CMD_DISPATCHER -- requirements
Module: heap_cmd_dispatcher

---
 rtl/heap_pkg.sv | 34 +++
 rtl/heap_cmd_fifo.sv | 55 +++++
 rtl/heap_cmd_dispatcher.sv | 136 +++++++++++++
 tb/tb_heap_cmd_dispatcher.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared opcodes, status codes, command layout and limits for the heap command dispatcher.
// Latency: none (declarations only).
// Backpressure: not applicable.
package heap_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_ILLEGAL = 2'b11
  } heap_op_e;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_FULL    = 3'd1,
    ST_EMPTY   = 3'd2,
    ST_ILLEGAL = 3'd3,
    ST_TIMEOUT = 3'd4
  } rsp_status_e;

  localparam int HEAP_CAPACITY = 1023;

  // One queued command: opcode in the top two bits, key below.
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] key;
  } cmd_t;

  // The heap's root output is meaningless while it holds nothing.
  function automatic logic [31:0] root_or_zero(input logic [9:0] n, input logic [31:0] root);
    return (n == 10'd0) ? 32'd0 : root;
  endfunction

endpackage

// File: rtl/heap_cmd_fifo.sv
// Generic show-ahead FIFO holding queued heap commands.
// Latency: a write is visible at rd_data on the following cycle.
// Backpressure: full blocks writes, empty blocks reads; push+pop together keep the count.
module heap_cmd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty masks stale entries.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/heap_cmd_dispatcher.sv
// Queues heap commands, screens them against heap state, drives the heap one at a time and returns a response.
// Latency: from an idle, empty queue, heap_start (or a rejection response) appears 3 cycles after acceptance.
// Backpressure: cmd_ready falls when the queue is full; the next command waits until rsp_ready takes the response.
module heap_cmd_dispatcher import heap_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int CAPACITY   = HEAP_CAPACITY,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_key,
  output logic        heap_start,
  output logic [1:0]  heap_instruction,
  output logic [31:0] heap_key,
  input  logic        heap_done,
  input  logic [9:0]  heap_n,
  input  logic [31:0] heap_root,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_status,
  output logic [31:0] rsp_root,
  output logic [9:0]  rsp_count
);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_DONE, CAPTURE, RESPOND} state_e;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [9:0]    CAP_N    = 10'(CAPACITY);

  state_e        state, state_nxt;
  cmd_t          fifo_wdat, fifo_rdat, cur_cmd;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic          rejected;
  logic [2:0]    rej_status;
  logic [TW-1:0] timer;
  logic          timed_out;

  assign fifo_wdat  = '{op: cmd_op, key: cmd_key};
  assign cmd_ready  = !fifo_full;
  assign heap_start = (state == ISSUE);
  assign rsp_valid  = (state == RESPOND);
  assign timed_out  = (state == WAIT_DONE) && !heap_done && (timer == TMO_LAST);

  heap_cmd_fifo #(.WIDTH(34), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cmd_valid),
    .wr_data (fifo_wdat),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Screen the current command against the heap before it is allowed to reach it.
  always_comb begin
    rejected   = 1'b1;
    rej_status = ST_ILLEGAL;
    if (cur_cmd.op == OP_ILLEGAL)                       rej_status = ST_ILLEGAL;
    else if (cur_cmd.op == OP_PUSH && heap_n >= CAP_N)  rej_status = ST_FULL;
    else if (cur_cmd.op == OP_POP && heap_n == 10'd0)   rej_status = ST_EMPTY;
    else                                                rejected   = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; the queue is only popped from IDLE so commands run strictly one at a time.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK:     state_nxt = rejected ? RESPOND : ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (heap_done)      state_nxt = CAPTURE;
        else if (timed_out) state_nxt = RESPOND;
      end
      CAPTURE:   state_nxt = RESPOND;
      RESPOND:   if (rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Command latch, heap drive, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_cmd          <= '0;
      heap_instruction <= '0;
      heap_key         <= '0;
      timer            <= '0;
      rsp_status       <= '0;
      rsp_root         <= '0;
      rsp_count        <= '0;
    end else begin
      if (fifo_pop) cur_cmd <= fifo_rdat;
      // Loaded once on the way into ISSUE so the heap sees stable operands until it finishes.
      if (state == CHECK && !rejected) begin
        heap_instruction <= cur_cmd.op;
        heap_key         <= cur_cmd.key;
      end
      if (state == ISSUE)          timer <= '0;
      else if (state == WAIT_DONE) timer <= timer + 1'b1;
      if (state == CHECK && rejected) begin
        rsp_status <= rej_status;
        rsp_root   <= root_or_zero(heap_n, heap_root);
        rsp_count  <= heap_n;
      end
      if (timed_out) begin
        rsp_status <= ST_TIMEOUT;
        rsp_root   <= '0;
        rsp_count  <= heap_n;
      end
      // heap_root settles the cycle after heap_done, which is this one.
      if (state == CAPTURE) begin
        rsp_status <= ST_OK;
        rsp_root   <= root_or_zero(heap_n, heap_root);
        rsp_count  <= heap_n;
      end
    end
  end

endmodule

// File: tb/tb_heap_cmd_dispatcher.sv
// Randomised scoreboard bench for heap_cmd_dispatcher with a behavioural max-heap on the heap side.
// Latency: checks start/response timing from an idle dispatcher and the timeout interval.
// Backpressure: rsp_ready is randomised or held low to fill the command queue.
module tb_heap_cmd_dispatcher;

  localparam int CAP = 1023;
  localparam int TMO = 4096;
  localparam logic [2:0] S_OK = 3'd0, S_FULL = 3'd1, S_EMPTY = 3'd2, S_ILLEGAL = 3'd3, S_TIMEOUT = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_key = 32'd0;
  logic        heap_start;
  logic [1:0]  heap_instruction;
  logic [31:0] heap_key;
  logic        heap_done = 1'b0;
  logic [9:0]  heap_n = 10'd0;
  logic [31:0] heap_root = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [2:0]  rsp_status;
  logic [31:0] rsp_root;
  logic [9:0]  rsp_count;

  heap_cmd_dispatcher #(.FIFO_DEPTH(8), .CAPACITY(CAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_key(cmd_key), .heap_start(heap_start),
    .heap_instruction(heap_instruction), .heap_key(heap_key), .heap_done(heap_done),
    .heap_n(heap_n), .heap_root(heap_root), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_root(rsp_root), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] st; logic [31:0] root; logic [9:0] cnt; } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_heap[$];
  logic [31:0] hw_heap[$];
  int errors = 0, checks = 0, cyc = 0;
  int exp_starts = 0, seen_starts = 0, rsp_popped = 0;
  int last_start_cyc = 0, last_rsp_cyc = 0, acc_cyc = 0;
  bit stall = 0, hold_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_root();
    logic [31:0] m = 32'd0;
    foreach (ref_heap[i]) if (ref_heap[i] > m) m = ref_heap[i];
    return m;
  endfunction

  function automatic void ref_pop_max();
    int idx = 0;
    foreach (ref_heap[i]) if (ref_heap[i] > ref_heap[idx]) idx = i;
    ref_heap.delete(idx);
  endfunction

  function automatic logic [31:0] hw_root();
    logic [31:0] m = 32'd0;
    foreach (hw_heap[i]) if (hw_heap[i] > m) m = hw_heap[i];
    return m;
  endfunction

  function automatic void hw_pop_max();
    int idx = 0;
    foreach (hw_heap[i]) if (hw_heap[i] > hw_heap[idx]) idx = i;
    hw_heap.delete(idx);
  endfunction

  // Reference: apply the dispatcher's rules to an abstract multiset in acceptance order.
  function automatic void ref_accept(input logic [1:0] op, input logic [31:0] key);
    exp_t e;
    if (op == 2'b11)
      e = '{S_ILLEGAL, ref_root(), 10'(ref_heap.size())};
    else if (op == 2'b01 && ref_heap.size() >= CAP)
      e = '{S_FULL, ref_root(), 10'(ref_heap.size())};
    else if (op == 2'b10 && ref_heap.size() == 0)
      e = '{S_EMPTY, 32'd0, 10'd0};
    else begin
      exp_starts++;
      if (stall) e = '{S_TIMEOUT, 32'd0, 10'(ref_heap.size())};
      else begin
        if (op == 2'b01) ref_heap.push_back(key);
        if (op == 2'b10) ref_pop_max();
        e = '{S_OK, ref_root(), 10'(ref_heap.size())};
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] key);
    bit ok;
    int waited;
    ok = 0;
    waited = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_key = key;
    while (!ok) begin
      @(negedge clk);
      ok = cmd_ready;
      acc_cyc = cyc;
      @(posedge clk);
      waited++;
      if (!ok && waited > 20000) begin
        checks++;
        errors++;
        $display("FAIL send_accept: cmd_ready stayed 0 for %0d cycles, required 1", waited);
        break;
      end
    end
    if (ok) ref_accept(op, key);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cmd_valid = 1'b0;
    exp_q.delete();
    ref_heap.delete();
    exp_starts = 0;
    seen_starts = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_heap_start", heap_start, 0);
    check("rst_heap_instruction", heap_instruction, 0);
    check("rst_heap_key", heap_key, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_root", rsp_root, 0);
    check("rst_rsp_count", rsp_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Heap model: random completion latency, optional stall, stray done pulses while not busy.
  initial begin
    int lat;
    bit busy;
    logic [1:0]  op;
    logic [31:0] key;
    lat = 0;
    busy = 0;
    op = 2'b00;
    key = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      heap_done = 1'b0;
      if (reset) begin
        busy = 0;
        hw_heap.delete();
      end else if (busy) begin
        lat--;
        if (lat == 0) begin
          check("heap_instr_stable", heap_instruction, op);
          check("heap_key_stable", heap_key, key);
          if (op == 2'b01) hw_heap.push_back(key);
          if (op == 2'b10 && hw_heap.size() != 0) hw_pop_max();
          heap_done = 1'b1;
          busy = 0;
        end
      end else if (heap_start) begin
        if (!stall) begin
          busy = 1;
          lat = $urandom_range(1, 4);
          op = heap_instruction;
          key = heap_key;
        end
      end else if (!stall && $urandom_range(0, 9) == 0) begin
        heap_done = 1'b1;
      end
      heap_n = 10'(hw_heap.size());
      heap_root = (hw_heap.size() == 0) ? 32'hDEAD_BEEF : hw_root();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: counts heap starts, timestamps responses and scores each handshake in order.
  initial begin
    bit prev_v;
    exp_t e;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 0;
        continue;
      end
      if (heap_start) begin
        seen_starts++;
        last_start_cyc = cyc;
      end
      if (rsp_valid && !prev_v) last_rsp_cyc = cyc;
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_popped++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: status=%0d root=%0d count=%0d, required no response",
                   rsp_status, rsp_root, rsp_count);
        end else begin
          e = exp_q.pop_front();
          if (rsp_status !== e.st || rsp_root !== e.root || rsp_count !== e.cnt) begin
            errors++;
            $display("FAIL rsp: status=%0d root=%0d count=%0d, required status=%0d root=%0d count=%0d",
                     rsp_status, rsp_root, rsp_count, e.st, e.root, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, popped0, ready_hi, valid_hi, r;
    do_reset();

    // push 5, 9, 3 then drain the heap, then pop on empty
    send(2'b01, 32'd5);
    send(2'b01, 32'd9);
    send(2'b01, 32'd3);
    send(2'b10, 32'd0);
    send(2'b10, 32'd0);
    send(2'b10, 32'd0);
    wait_drain(500);
    s0 = seen_starts;
    send(2'b10, 32'd0);
    wait_drain(500);
    check("empty_no_start", seen_starts, s0);
    check("reject_latency", last_rsp_cyc - acc_cyc, 3);
    send(2'b01, 32'd11);
    wait_drain(500);
    check("start_latency", last_start_cyc - acc_cyc, 3);
    send(2'b11, $urandom);
    wait_drain(500);

    // stalled heap -> timeout
    stall = 1;
    send(2'b01, 32'd77);
    wait_drain(TMO + 200);
    stall = 0;
    check("timeout_interval", last_rsp_cyc - last_start_cyc, TMO + 1);

    // fill the queue behind a parked response
    hold_rsp = 1;
    send(2'b00, 32'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("parked_rsp_valid", rsp_valid, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(2'b01, 32'(100 + i));
    ready_hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (cmd_ready) ready_hi++;
    end
    check("ready_low_when_full", ready_hi, 0);
    @(posedge clk);
    #1;
    popped0 = rsp_popped;
    hold_rsp = 0;
    send(2'b01, 32'd200);
    check("ninth_after_drain", rsp_popped > popped0, 1);
    wait_drain(2000);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      send((r < 5) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain(5000);
    check("start_count", seen_starts, exp_starts);

    // heap at capacity
    hw_heap.delete();
    ref_heap.delete();
    for (int i = 0; i < CAP; i++) begin
      r = $urandom;
      hw_heap.push_back(32'(r));
      ref_heap.push_back(32'(r));
    end
    repeat (3) @(posedge clk);
    #1;
    s0 = seen_starts;
    send(2'b01, 32'd7);
    wait_drain(500);
    check("full_no_start", seen_starts, s0);
    send(2'b00, 32'd0);
    send(2'b10, 32'd0);
    wait_drain(500);

    // reset with work queued and in flight
    send(2'b01, 32'd1);
    send(2'b01, 32'd2);
    send(2'b10, 32'd0);
    repeat (4) @(posedge clk);
    do_reset();
    valid_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) valid_hi++;
    end
    check("post_reset_no_rsp", valid_hi, 0);
    check("post_reset_no_start", seen_starts, 0);
    @(posedge clk);
    #1;
    send(2'b01, 32'd1);
    wait_drain(500);
    check("final_start_count", seen_starts, exp_starts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
